// File: rtl/cache_controller.sv
// cache_controller: 2-way set-associative, write-through, no-write-allocate read cache between MEM and SRAM.
// Optional saturating hit/miss counters (hit_count/miss_count ports) exist when CACHE_STATS_EN is defined.
module cache_controller #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 10
`ifdef CACHE_STATS_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        sram_rd_en,
    output logic        sram_wr_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
`endif
);

    localparam int SETS = 1 << INDEX_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RMISS = 2'd1,
        WRITE = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Storage: per way a tag and a 64-bit block per set; valid and LRU per set.
    logic [TAG_W-1:0] tag_q   [2][SETS];
    logic [63:0]      data_q  [2][SETS];
    logic [SETS-1:0]  valid_q [2];
    logic [SETS-1:0]  lru_q;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               word_sel;

    assign idx      = address[INDEX_W+2:3];
    assign tag      = address[TAG_W+INDEX_W+2:INDEX_W+3];
    assign word_sel = address[2];

    logic        hit0, hit1, hit, hit_way, victim_way;
    logic [63:0] hit_block;

    assign hit0       = valid_q[0][idx] && (tag_q[0][idx] == tag);
    assign hit1       = valid_q[1][idx] && (tag_q[1][idx] == tag);
    assign hit        = hit0 || hit1;
    assign hit_way    = hit1;
    assign hit_block  = hit_way ? data_q[1][idx] : data_q[0][idx];
    assign victim_way = !valid_q[0][idx] ? 1'b0 :
                        !valid_q[1][idx] ? 1'b1 : lru_q[idx];

    // Array write port, driven by the FSM below.
    logic        arr_we;
    logic        arr_way;
    logic [63:0] block_d;
    logic        valid_set;
    logic        lru_en;
    logic        lru_val;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        ready     = 1'b0;
        arr_we    = 1'b0;
        arr_way   = victim_way;
        block_d   = sram_rdata;
        valid_set = 1'b0;
        lru_en    = 1'b0;
        lru_val   = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_en) begin
                    state_d = WRITE;
                end else if (rd_en) begin
                    if (hit) begin
                        ready   = 1'b1;
                        lru_en  = 1'b1;
                        lru_val = ~hit_way;
                    end else begin
                        state_d = RMISS;
                    end
                end else begin
                    ready = 1'b1;
                end
            end
            RMISS: begin
                if (sram_ready) begin
                    arr_we    = 1'b1;
                    arr_way   = victim_way;
                    block_d   = sram_rdata;
                    valid_set = 1'b1;
                    lru_en    = 1'b1;
                    lru_val   = ~victim_way;
                    ready     = 1'b1;
                    state_d   = IDLE;
                end
            end
            WRITE: begin
                if (sram_ready) begin
                    // Write-through: a resident block takes the new word, a miss allocates nothing.
                    if (hit) begin
                        arr_we  = 1'b1;
                        arr_way = hit_way;
                        block_d = word_sel ? {write_data, hit_block[31:0]}
                                           : {hit_block[63:32], write_data};
                        lru_en  = 1'b1;
                        lru_val = ~hit_way;
                    end
                    ready   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: reset is synchronous and active-low; all clocked state is updated with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            lru_q      <= '0;
        end else begin
            if (valid_set) valid_q[arr_way][idx] <= 1'b1;
            if (lru_en)    lru_q[idx]            <= lru_val;
        end
    end

    // NOTE: tag/data arrays carry no reset; their contents are only trusted behind valid_q.
    always_ff @(posedge clk) begin
        if (arr_we) begin
            tag_q[arr_way][idx]  <= tag;
            data_q[arr_way][idx] <= block_d;
        end
    end

    assign sram_rd_en   = (state_q == RMISS);
    assign sram_wr_en   = (state_q == WRITE);
    assign sram_address = sram_rd_en ? {address[31:3], 3'b000} : address;
    assign sram_wdata   = write_data;

    always_comb begin
        read_data = word_sel ? hit_block[63:32] : hit_block[31:0];
        if (state_q == RMISS) begin
            read_data = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
        end
    end

`ifdef CACHE_STATS_EN
    logic             hit_evt, miss_evt;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    assign hit_evt  = (state_q == IDLE) && rd_en && !wr_en && hit;
    assign miss_evt = (state_q == IDLE) && (state_d == RMISS);

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit_evt && (hit_cnt_q != '1))   hit_cnt_d  = hit_cnt_q + 1'b1;
        if (miss_evt && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: a word-addressed SRAM model answers block reads and
// word writes; expected load data is queued at issue and compared when the cache reports ready.
module tb_cache_controller;

    localparam int SRAM_LAT = 2;
    localparam int BUDGET   = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        ready;
    logic        sram_rd_en, sram_wr_en;
    logic [31:0] sram_address, sram_wdata;
    logic [63:0] sram_rdata;
    logic        sram_ready;
`ifdef CACHE_STATS_EN
    logic [3:0]  hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    cache_controller #(
        .INDEX_W(6),
        .TAG_W  (10)
`ifdef CACHE_STATS_EN
        ,
        .CNT_W  (4)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_rd_en  (sram_rd_en),
        .sram_wr_en  (sram_wr_en),
        .sram_address(sram_address),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata),
        .sram_ready  (sram_ready)
`ifdef CACHE_STATS_EN
        ,
        .hit_count   (hit_count),
        .miss_count  (miss_count)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    logic [31:0] sb_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Backing store, word addressed; untouched words return a fixed address-derived pattern.
    logic [31:0] mem [int unsigned];
    bit          sram_stall = 1'b0;
    int          sram_cnt   = 0;

    function automatic logic [31:0] mem_rd(input int unsigned w);
        if (mem.exists(w)) return mem[w];
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    initial begin
        int unsigned blk;
        sram_ready = 1'b0;
        sram_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst || !(sram_rd_en || sram_wr_en) || sram_ready) begin
                sram_ready = 1'b0;
                sram_cnt   = 0;
            end else if (!sram_stall) begin
                sram_cnt++;
                if (sram_cnt == SRAM_LAT) begin
                    sram_ready = 1'b1;
                    if (sram_rd_en) begin
                        blk        = {2'b00, sram_address[31:3], 1'b0};
                        sram_rdata = {mem_rd(blk + 1), mem_rd(blk)};
                    end else begin
                        mem[{2'b00, sram_address[31:2]}] = sram_wdata;
                    end
                end
            end
        end
    end

    // Issues one load at a negedge; returns at the negedge after the load completes.
    task automatic do_read(input logic [31:0] addr, input bit exp_hit, input string tag);
        int          cyc;
        logic [31:0] exp;
        exp = mem_rd({2'b00, addr[31:2]});
        sb_q.push_back(exp);
        rd_en = 1'b1; wr_en = 1'b0; address = addr; write_data = '0;
        #1;
        check({tag, "_ready_now"}, ready, exp_hit);
        if (exp_hit) begin
            check({tag, "_no_sram"}, {sram_rd_en, sram_wr_en}, 2'b00);
            exp_hits++;
        end else begin
            exp_misses++;
        end
        cyc = 0;
        while (!ready && cyc < BUDGET) begin
            @(negedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                check({tag, "_sram_rd_en"}, sram_rd_en, 1'b1);
                check({tag, "_sram_addr"}, sram_address, {addr[31:3], 3'b000});
            end
        end
        if (!exp_hit) check({tag, "_latency"}, cyc, SRAM_LAT);
        if (sb_q.size() > 0) check({tag, "_data"}, read_data, sb_q.pop_front());
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input string tag);
        int cyc;
        wr_en = 1'b1; rd_en = 1'b0; address = addr; write_data = data;
        #1;
        check({tag, "_ready_now"}, ready, 1'b0);
        cyc = 0;
        while (!ready && cyc < BUDGET) begin
            @(negedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                check({tag, "_sram_wr_en"}, {sram_wr_en, sram_rd_en}, 2'b10);
                check({tag, "_sram_addr"}, sram_address, addr);
                check({tag, "_sram_wdata"}, sram_wdata, data);
            end
        end
        check({tag, "_latency"}, cyc, SRAM_LAT);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
        mem[0] = 32'h0000_0011;
        mem[1] = 32'h0000_0022;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_ready", ready, 1'b1);
        check("reset_sram_en", {sram_rd_en, sram_wr_en}, 2'b00);
`ifdef CACHE_STATS_EN
        check("reset_counts", {hit_count, miss_count}, 8'h00);
`endif
        @(negedge clk);

        // Cold miss, then a hit on the same word and on the other word of the block.
        do_read(32'h000, 1'b0, "s1_miss");
        do_read(32'h000, 1'b1, "s1_hit");
`ifdef CACHE_STATS_EN
        #1;
        check("s6_miss_count", miss_count, 4'd1);
        check("s6_hit_count", hit_count, 4'd1);
`endif
        do_read(32'h004, 1'b1, "s2_odd_hit");

        // Three tags into set 0: the third evicts the least-recently-used tag 0.
        do_read(32'h000, 1'b1, "s3_t0_hit");
        do_read(32'h200, 1'b0, "s3_t1_miss");
        do_read(32'h400, 1'b0, "s3_t2_miss");
        do_read(32'h200, 1'b1, "s3_t1_hit");
        do_read(32'h000, 1'b0, "s3_t0_evicted");
        do_read(32'h404, 1'b0, "s3_t2_evicted");

        // Write-through hit updates the cached word; a write miss allocates nothing.
        do_read(32'h008, 1'b0, "s4_load");
        do_write(32'h008, 32'hDEAD_BEEF, "s4_wr_hit");
        do_read(32'h008, 1'b1, "s4_rd_after_wr");
        do_read(32'h00C, 1'b1, "s4_other_word");
        do_write(32'h00C, 32'h1234_5678, "s4_wr_odd");
        do_read(32'h00C, 1'b1, "s4_rd_odd");
        do_read(32'h008, 1'b1, "s4_even_kept");
        do_write(32'h1000, 32'hCAFE_F00D, "s4_wr_miss");
        do_read(32'h1000, 1'b0, "s4_no_alloc");

        // Reset while a refill is outstanding aborts it and clears every valid bit.
        sram_stall = 1'b1;
        rd_en = 1'b1; address = 32'h600;
        #1;
        check("s5_ready_now", ready, 1'b0);
        @(negedge clk); #1;
        check("s5_in_rmiss", sram_rd_en, 1'b1);
        @(negedge clk);
        rst = 1'b0; rd_en = 1'b0;
        @(negedge clk); #1;
        check("s5_abort_sram", sram_rd_en, 1'b0);
        check("s5_abort_ready", ready, 1'b1);
        rst = 1'b1; sram_stall = 1'b0;
        exp_hits = 0; exp_misses = 0;
`ifdef CACHE_STATS_EN
        check("s5_counts_cleared", {hit_count, miss_count}, 8'h00);
`endif
        @(negedge clk);
        do_read(32'h000, 1'b0, "s5_valid_cleared");
        do_read(32'h000, 1'b1, "s5_refilled");

`ifdef CACHE_STATS_EN
        // Hold a hitting load for more cycles than the counter can count.
        rd_en = 1'b1; address = 32'h000;
        repeat (20) @(negedge clk);
        rd_en = 1'b0;
        exp_hits += 20;
        #1;
        check("s6_hit_saturated", hit_count, (exp_hits > 15) ? 4'hF : 4'(exp_hits));
        check("s6_miss_final", miss_count, (exp_misses > 15) ? 4'hF : 4'(exp_misses));
        @(negedge clk);
`endif

        check("scoreboard_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
